// File: rtl/mod_inv_seq.sv
// Sequential modular inverse over a prime field (binary extended Euclid).
// One reduction step per RUN cycle; result and error flag are registered
// and held until the next accepted start.
module mod_inv_seq #(
    parameter logic [255:0] P        = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F,
    parameter int unsigned  MAX_ITER = 1100
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] input_num,
    output logic [255:0] inverse,
    output logic         busy,
    output logic         done,
    output logic         error
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [10:0] ITER_LIMIT = 11'(MAX_ITER);

    state_t       state_q, state_d;
    logic [255:0] u_q, u_d;
    logic [255:0] v_q, v_d;
    logic [255:0] x1_q, x1_d;
    logic [255:0] x2_q, x2_d;
    logic [255:0] inv_q, inv_d;
    logic [10:0]  cnt_q, cnt_d;
    logic         err_q, err_d;

    logic         u_one, v_one, op_bad;

    // x/2 mod P: odd values get P added first; the sum needs 257 bits.
    function automatic logic [255:0] half_mod(input logic [255:0] x);
        logic [256:0] s;
        s = x[0] ? ({1'b0, x} + {1'b0, P}) : {1'b0, x};
        return 256'(s >> 1);
    endfunction

    // (x - y) mod P for x, y already in [0, P-1]; wrap-around of the
    // 256-bit difference is undone by adding P back.
    function automatic logic [255:0] sub_mod(input logic [255:0] x, input logic [255:0] y);
        return (x >= y) ? (x - y) : (x - y + P);
    endfunction

    assign u_one  = (u_q == 256'd1);
    assign v_one  = (v_q == 256'd1);
    assign op_bad = (input_num == 256'd0) || (input_num >= P);

    // Next-state and datapath: start handling in IDLE, one Euclid step in RUN.
    always_comb begin
        state_d = state_q;
        u_d     = u_q;
        v_d     = v_q;
        x1_d    = x1_q;
        x2_d    = x2_q;
        inv_d   = inv_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    u_d   = input_num;
                    v_d   = P;
                    x1_d  = 256'd1;
                    x2_d  = 256'd0;
                    cnt_d = 11'd0;
                    inv_d = 256'd0;
                    err_d = 1'b0;
                    if (op_bad) begin
                        // Zero and out-of-field operands have no inverse.
                        err_d   = 1'b1;
                        state_d = FINISH;
                    end else begin
                        state_d = RUN;
                    end
                end
            end

            RUN: begin
                cnt_d = cnt_q + 11'd1;
                if (u_one) begin
                    inv_d   = x1_q;
                    state_d = FINISH;
                end else if (v_one) begin
                    inv_d   = x2_q;
                    state_d = FINISH;
                end else if (cnt_q == ITER_LIMIT) begin
                    // Safety net: never reached for a prime modulus.
                    inv_d   = 256'd0;
                    err_d   = 1'b1;
                    state_d = FINISH;
                end else if (!u_q[0]) begin
                    u_d  = u_q >> 1;
                    x1_d = half_mod(x1_q);
                end else if (!v_q[0]) begin
                    v_d  = v_q >> 1;
                    x2_d = half_mod(x2_q);
                end else if (u_q >= v_q) begin
                    u_d  = u_q - v_q;
                    x1_d = sub_mod(x1_q, x2_q);
                end else begin
                    v_d  = v_q - u_q;
                    x2_d = sub_mod(x2_q, x1_q);
                end
            end

            FINISH: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            u_q     <= '0;
            v_q     <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            inv_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            u_q     <= u_d;
            v_q     <= v_d;
            x1_q    <= x1_d;
            x2_q    <= x2_d;
            inv_q   <= inv_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign inverse = inv_q;
    assign error   = err_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == FINISH);

endmodule

// File: doc/mod_inv_seq.md
MOD_INV_SEQ -- requirements
Module: mod_inv_seq

Interface
REQ-001 SHALL have parameter P, default 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F, the secp256k1 field prime.
REQ-002 SHALL have parameter MAX_ITER, default 1100, the RUN-cycle limit before abort.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port start, input, 1, request pulse, sampled only in IDLE.
REQ-006 SHALL have port input_num, input, 256, operand a, sampled on start acceptance.
REQ-007 SHALL have port inverse, output, 256, registered result a^-1 mod P.
REQ-008 SHALL have port busy, output, 1, high in RUN and FINISH.
REQ-009 SHALL have port done, output, 1, single-cycle completion strobe.
REQ-010 SHALL have port error, output, 1, valid with done; high for invalid operand or iteration abort.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, FINISH; IDLE->RUN on accepted start; RUN->FINISH on termination; FINISH->IDLE unconditionally after one cycle.
REQ-012 SHALL, on start in IDLE, load u=a, v=P, x1=1, x2=0 and clear the 11-bit iteration counter.
REQ-013 SHALL, on start with a==0 or a>=P, go to FINISH directly, with inverse=0 and error=1.
REQ-014 SHALL perform exactly one step per RUN cycle, in priority order: u==1 -> result x1; v==1 -> result x2; u even -> u=u/2 and x1 halved mod P; v even -> v=v/2 and x2 halved mod P; u>=v -> u=u-v, x1=x1-x2 mod P; else v=v-u, x2=x2-x1 mod P.
REQ-015 SHALL halve mod P as x/2 if x even, else (x+P)/2 computed at 257 bits; the result SHALL stay in [0,P-1].
REQ-016 SHALL subtract mod P as x-y if x>=y, else x-y+P; the result SHALL stay in [0,P-1].
REQ-017 SHALL, when the counter reaches MAX_ITER in RUN without termination, go to FINISH with inverse=0 and error=1.
REQ-018 SHALL register inverse on the RUN->FINISH transition and hold it until the next accepted start.
REQ-019 SHALL assert done for exactly the FINISH cycle; error SHALL be valid that cycle and held until the next accepted start.
REQ-020 SHALL ignore start while busy; operands and the in-flight operation SHALL be unaffected.
REQ-021 SHALL accept start in the cycle immediately after FINISH, i.e. back-to-back operations.
REQ-022 SHALL make the latency from the start-accept edge to done high 2+N cycles, where N is the number of RUN steps; N SHALL be <=1030 for valid a.

Reset
REQ-023 SHALL, with rst high at a clock edge, force IDLE and set inverse=0, done=0, busy=0, error=0, u=v=x1=x2=0 and counter=0.
REQ-024 SHALL give rst priority over start and abort any in-flight operation with no done pulse.

Verification
REQ-025 SHALL verify: a=1, start at cycle 0 -> done at cycle 2, inverse=1, error=0.
REQ-026 SHALL verify: a=2 -> done at cycle 3, inverse=7FFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_7FFFFE18.
REQ-027 SHALL verify: a=P-1 -> inverse=P-1; 1000 random a in [1,P-1] -> (a*inverse) mod P == 1 per reference model, with N<=1030.
REQ-028 SHALL verify: a=0 and a=P -> done one cycle after start, error=1, inverse=0.
REQ-029 SHALL verify: start pulsed while busy -> ignored, first result is correct; rst asserted mid-RUN -> next cycle IDLE, all outputs 0, no done.
REQ-030 SHALL verify: start in the cycle after done -> second operation accepted and correct.
